// File: rtl/mac3_stream.sv
`default_nettype none
// ============================================================================
//  Module      : mac3_stream
//  Description : Streaming three-sample multiply-accumulate engine.
//                Keeps a sliding window of the last two valid samples and,
//                for every third consecutive valid sample, issues
//                a*b+c (mode=0) or a*b-c (mode=1), where a is the oldest,
//                b the middle and c the newest (incoming) sample. Results
//                are wrapped or saturated to WIDTH bits and travel through a
//                LAT-stage output pipeline.
//
//  Parameters  : WIDTH  sample/result width in bits (>= 2)
//                LAT    result latency in cycles after the edge sampling c (1..4)
//                SAT    0 = wrap to WIDTH bits, 1 = clamp to [0, 2^WIDTH-1]
//
//  Ports       : clk       in   rising-edge clock
//                rst_n     in   asynchronous active-low reset
//                validi    in   data_in is valid this cycle
//                mode      in   0 = add c, 1 = subtract c (used on issue edges)
//                data_in   in   unsigned sample, WIDTH bits
//                valido    out  data_out/ovf are valid this cycle
//                data_out  out  result, WIDTH bits (0 when valido=0)
//                ovf       out  exact result fell outside [0, 2^WIDTH-1]
//
//  Revision    : 1.0  initial release
// ============================================================================
module mac3_stream #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             validi,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             valido,
    output logic [WIDTH-1:0] data_out,
    output logic             ovf
);

    // Intermediate is 2*WIDTH+1 bits: the largest a*b+c is below 2^(2*WIDTH)
    // and the smallest a*b-c is above -2^WIDTH, so one extra sign bit makes
    // the computation exact.
    localparam int c_RW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_win_old;
    logic [WIDTH-1:0] r_win_new;

    logic             w_issue;
    logic [2*WIDTH-1:0] w_prod;
    logic [c_RW-1:0]  w_c_ext;
    logic [c_RW-1:0]  w_r;
    logic             w_neg;
    logic             w_big;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    // Pipeline stage storage; index 0 is loaded on the issue edge, index
    // LAT-1 drives the outputs.
    logic             r_pv [LAT];
    logic [WIDTH-1:0] r_pd [LAT];
    logic             r_po [LAT];

    // ------------------------------------------------------------------------
    // Window FSM. A valid sample always shifts into the window; a gap flushes
    // the window so no result ever mixes samples from different bursts.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_win_old <= '0;
            r_win_new <= '0;
        end else if (validi) begin
            r_win_old <= r_win_new;
            r_win_new <= data_in;
            case (r_state)
                ST_EMPTY: r_state <= ST_ONE;
                ST_ONE:   r_state <= ST_TWO;
                default:  r_state <= ST_RUN;
            endcase
        end else begin
            r_state   <= ST_EMPTY;
            r_win_old <= '0;
            r_win_new <= '0;
        end
    end

    assign w_issue = validi && ((r_state == ST_TWO) || (r_state == ST_RUN));

    // ------------------------------------------------------------------------
    // Exact arithmetic. Operands are zero-extended so the subtraction result
    // is a two's-complement value whose top bit is the sign.
    // ------------------------------------------------------------------------
    assign w_prod  = {{WIDTH{1'b0}}, r_win_old} * {{WIDTH{1'b0}}, r_win_new};
    assign w_c_ext = {{(WIDTH + 1){1'b0}}, data_in};
    assign w_r     = mode ? ({1'b0, w_prod} - w_c_ext)
                          : ({1'b0, w_prod} + w_c_ext);

    assign w_neg = w_r[c_RW-1];
    // Any set bit above WIDTH on a non-negative value means r > 2^WIDTH-1.
    assign w_big = !w_neg && (|w_r[2*WIDTH-1:WIDTH]);
    assign w_ovf = w_neg || w_big;

    generate
        if (SAT != 0) begin : g_sat
            assign w_res = w_neg ? '0 : (w_big ? '1 : w_r[WIDTH-1:0]);
        end else begin : g_wrap
            assign w_res = w_r[WIDTH-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output pipeline. Every edge loads stage 0 (a bubble when not issuing)
    // and shifts the rest, so in-flight results survive window breaks.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
                r_po[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pd[0] <= w_issue ? w_res : '0;
            r_po[0] <= w_issue && w_ovf;
            for (int i = LAT - 1; i > 0; i--) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_po[i] <= r_po[i-1];
            end
        end
    end

    assign valido   = r_pv[LAT-1];
    assign data_out = r_pv[LAT-1] ? r_pd[LAT-1] : '0;
    assign ovf      = r_pv[LAT-1] && r_po[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_mac3_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac3_stream
//  Description : Self-checking bench for mac3_stream. Four instances share one
//                stimulus stream: 32-bit/LAT1/wrap, 8-bit/LAT1/sat,
//                8-bit/LAT1/wrap and 32-bit/LAT3/wrap. A bench-side window
//                model pushes expected results into a scoreboard, and a
//                monitor compares every cycle of every instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mac3_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validi;
    logic        mode;
    logic [31:0] data_in;

    logic        v_a, v_b, v_c, v_d;
    logic [31:0] d_a, d_d;
    logic [7:0]  d_b, d_c;
    logic        o_a, o_b, o_c, o_d;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          id;
        int          cyc;
        logic [31:0] d;
        logic        o;
    } exp_t;

    exp_t sb[$];

    // bench-side window model
    int          m_st  = 0;
    logic [31:0] m_old = '0;
    logic [31:0] m_new = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac3_stream #(.WIDTH(32), .LAT(1), .SAT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .validi(validi), .mode(mode),
        .data_in(data_in), .valido(v_a), .data_out(d_a), .ovf(o_a));
    mac3_stream #(.WIDTH(8), .LAT(1), .SAT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .validi(validi), .mode(mode),
        .data_in(data_in[7:0]), .valido(v_b), .data_out(d_b), .ovf(o_b));
    mac3_stream #(.WIDTH(8), .LAT(1), .SAT(0)) u_c (
        .clk(clk), .rst_n(rst_n), .validi(validi), .mode(mode),
        .data_in(data_in[7:0]), .valido(v_c), .data_out(d_c), .ovf(o_c));
    mac3_stream #(.WIDTH(32), .LAT(3), .SAT(0)) u_d (
        .clk(clk), .rst_n(rst_n), .validi(validi), .mode(mode),
        .data_in(data_in), .valido(v_d), .data_out(d_d), .ovf(o_d));

    function automatic int cfg_w(input int k);
        return (k == 1 || k == 2) ? 8 : 32;
    endfunction
    function automatic int cfg_lat(input int k);
        return (k == 3) ? 3 : 1;
    endfunction
    function automatic int cfg_sat(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    // Reference arithmetic in a wide vector, independent of the RTL structure.
    function automatic exp_t calc(input int w, input int s, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] c,
                                  input logic m);
        exp_t        e;
        logic [80:0] mx, r, am, bm, cm;
        mx = (81'd1 << w) - 81'd1;
        am = {49'd0, a} & mx;
        bm = {49'd0, b} & mx;
        cm = {49'd0, c} & mx;
        r  = am * bm;
        r  = m ? (r - cm) : (r + cm);
        e.id  = 0;
        e.cyc = 0;
        e.o   = r[80] || (r > mx);
        if (s != 0 && r[80])      e.d = 32'd0;
        else if (s != 0 && e.o)   e.d = mx[31:0];
        else                      e.d = r[31:0] & mx[31:0];
        return e;
    endfunction

    task automatic step(input logic v, input logic m, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        validi  = v;
        mode    = m;
        data_in = d;
        if (v) begin
            if (m_st >= 2) begin
                for (int k = 0; k < 4; k++) begin
                    e     = calc(cfg_w(k), cfg_sat(k), m_old, m_new, d, m);
                    e.id  = k;
                    e.cyc = cyc + cfg_lat(k);
                    sb.push_back(e);
                end
            end
            m_old = m_new;
            m_new = d;
            if (m_st < 3) m_st++;
        end else begin
            m_st  = 0;
            m_old = '0;
            m_new = '0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    // Per-cycle scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic        mv [4];
        logic [31:0] md [4];
        logic        mo [4];
        mv[0] = v_a; md[0] = d_a;          mo[0] = o_a;
        mv[1] = v_b; md[1] = {24'd0, d_b}; mo[1] = o_b;
        mv[2] = v_c; md[2] = {24'd0, d_c}; mo[2] = o_c;
        mv[3] = v_d; md[3] = d_d;          mo[3] = o_d;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = -1;
            for (int j = 0; j < sb.size(); j++)
                if (idx < 0 && sb[j].id == k) idx = j;
            checks++;
            if (idx >= 0 && sb[idx].cyc < cyc) begin
                errors++;
                $display("FAIL missing_result dut%0d: expected data %0d at cycle %0d, not seen",
                         k, sb[idx].d, sb[idx].cyc);
                sb.delete(idx);
            end else if (idx >= 0 && sb[idx].cyc == cyc) begin
                if (mv[k] !== 1'b1 || md[k] !== sb[idx].d || mo[k] !== sb[idx].o) begin
                    errors++;
                    $display("FAIL result dut%0d cyc%0d: got v=%0b d=%0d ovf=%0b, expected v=1 d=%0d ovf=%0b",
                             k, cyc, mv[k], md[k], mo[k], sb[idx].d, sb[idx].o);
                end
                sb.delete(idx);
            end else begin
                if (mv[k] !== 1'b0 || md[k] !== 32'd0 || mo[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle dut%0d cyc%0d: got v=%0b d=%0d ovf=%0b, expected v=0 d=0 ovf=0",
                             k, cyc, mv[k], md[k], mo[k]);
                end
            end
        end
    end

    task automatic test_reset;
        rst_n   = 1'b0;
        validi  = 1'b1;
        mode    = 1'b0;
        data_in = 32'd7;
        #1;
        checks++;
        if ({v_a, v_b, v_c, v_d, o_a, o_b, o_c, o_d} !== 8'd0 || d_a !== 0 || d_d !== 0) begin
            errors++;
            $display("FAIL reset_initial: got v=%b%b%b%b d_a=%0d, expected all 0", v_a, v_b, v_c, v_d, d_a);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({v_a, v_b, v_c, v_d} !== 4'd0 || d_a !== 0 || d_b !== 0) begin
            errors++;
            $display("FAIL reset_held: got v=%b%b%b%b d_a=%0d, expected all 0", v_a, v_b, v_c, v_d, d_a);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        validi = 1'b0;
        m_st   = 0;
    endtask

    task automatic test_basic;
        step(1'b1, 1'b0, 32'd2);
        step(1'b1, 1'b0, 32'd3);
        step(1'b1, 1'b0, 32'd4);
        @(posedge clk); #1;
        checks++;
        if (v_a !== 1'b1 || d_a !== 32'd10 || o_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got v=%0b d=%0d ovf=%0b, expected v=1 d=10 ovf=0", v_a, d_a, o_a);
        end
        step(1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        checks++;
        if (v_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: got v=%0b, expected 0", v_a);
        end
        idle(4);
    endtask

    task automatic test_sliding;
        for (int i = 2; i <= 6; i++) step(1'b1, 1'b0, 32'(i));
        idle(4);
    endtask

    task automatic test_break_refill;
        step(1'b1, 1'b0, 32'd1);
        step(1'b1, 1'b0, 32'd2);
        step(1'b0, 1'b0, 32'd99);
        step(1'b1, 1'b0, 32'd3);
        step(1'b1, 1'b0, 32'd4);
        step(1'b1, 1'b0, 32'd5);
        @(posedge clk); #1;
        checks++;
        if (v_a !== 1'b1 || d_a !== 32'd17) begin
            errors++;
            $display("FAIL refill_result: got v=%0b d=%0d, expected v=1 d=17", v_a, d_a);
        end
        idle(4);
    endtask

    task automatic test_sat;
        step(1'b1, 1'b0, 32'd1);
        step(1'b1, 1'b0, 32'd1);
        step(1'b1, 1'b1, 32'd5);
        @(posedge clk); #1;
        checks++;
        if (v_b !== 1'b1 || d_b !== 8'd0 || o_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_sub_neg: got v=%0b d=%0d ovf=%0b, expected v=1 d=0 ovf=1", v_b, d_b, o_b);
        end
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'd16);
        step(1'b1, 1'b1, 32'd16);
        step(1'b1, 1'b0, 32'd1);
        @(posedge clk); #1;
        checks++;
        if (d_b !== 8'd255 || o_b !== 1'b1 || d_c !== 8'd1 || o_c !== 1'b1) begin
            errors++;
            $display("FAIL sat_wrap_257: got sat d=%0d ovf=%0b wrap d=%0d ovf=%0b, expected 255/1 and 1/1",
                     d_b, o_b, d_c, o_c);
        end
        idle(4);
    endtask

    task automatic test_latency;
        step(1'b1, 1'b0, 32'd2);
        step(1'b1, 1'b0, 32'd3);
        step(1'b1, 1'b0, 32'd4);
        @(posedge clk); #1;
        checks++;
        if (v_d !== 1'b0) begin
            errors++;
            $display("FAIL lat3_early0: got v=%0b, expected 0", v_d);
        end
        step(1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        checks++;
        if (v_d !== 1'b0) begin
            errors++;
            $display("FAIL lat3_early1: got v=%0b, expected 0", v_d);
        end
        step(1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        checks++;
        if (v_d !== 1'b1 || d_d !== 32'd10) begin
            errors++;
            $display("FAIL lat3_result: got v=%0b d=%0d, expected v=1 d=10", v_d, d_d);
        end
        idle(4);
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) d = $urandom_range(0, 300);
            else                           d = $urandom;
            step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), d);
        end
        idle(4);
    endtask

    task automatic test_async_reset;
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'(i + 10));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_st  = 0;
        m_old = '0;
        m_new = '0;
        #1;
        checks++;
        if ({v_a, v_b, v_c, v_d, o_a, o_b, o_c, o_d} !== 8'd0 ||
            d_a !== 0 || d_b !== 0 || d_c !== 0 || d_d !== 0) begin
            errors++;
            $display("FAIL async_reset: got v=%b%b%b%b d_a=%0d d_d=%0d, expected all 0",
                     v_a, v_b, v_c, v_d, d_a, d_d);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        validi = 1'b0;
        step(1'b1, 1'b0, 32'd2);
        step(1'b1, 1'b0, 32'd3);
        step(1'b1, 1'b0, 32'd4);
        idle(5);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_sliding();
        test_break_refill();
        test_sat();
        step(1'b1, 1'b1, 32'd7);   // mode toggles on non-issue edges
        step(1'b1, 1'b1, 32'd9);
        step(1'b1, 1'b0, 32'd3);
        idle(4);
        test_latency();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding results, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
